// File: rtl/unified_mem_wbuf.sv
// unified_mem_wbuf: parametrised unified instruction/data memory.
//  - Combinational fetch and CPU data reads (out-of-range addresses read as 0).
//  - CPU write port never stalls.
//  - Handshaked IO port; IO writes are parked in a small write buffer that
//    drains one entry per cycle whenever the CPU is not writing.
// Optional feature macro: MEM_CLEAR_EN
//  - defined:   RST starts a sweep that zeroes every word, one per cycle (BUSY=1).
//  - undefined: BUSY tied low, RST leaves memory contents untouched.
module unified_mem_wbuf #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned WBUF_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] IF_ADDR,
    output logic [DATA_W-1:0] IF_DATA,
    input  logic [ADDR_W-1:0] CPU_RADDR,
    output logic [DATA_W-1:0] CPU_RDATA,
    input  logic              CPU_WE,
    input  logic [ADDR_W-1:0] CPU_WADDR,
    input  logic [DATA_W-1:0] CPU_WDATA,
    input  logic              IO_REQ,
    input  logic              IO_WE,
    input  logic [ADDR_W-1:0] IO_ADDR,
    input  logic [DATA_W-1:0] IO_WDATA,
    output logic              IO_ACK,
    output logic [DATA_W-1:0] IO_RDATA,
    output logic              WBUF_EMPTY,
    output logic              WBUF_FULL,
    output logic              BUSY,
    output logic              ERR_OOR
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK     = 2'd2;
    localparam logic [1:0] ST_CLEAR   = 2'd3;

`ifdef MEM_CLEAR_EN
    localparam logic [1:0] ST_RESET = ST_CLEAR;
`else
    localparam logic [1:0] ST_RESET = ST_IDLE;
`endif

    // Widened compare so DEPTH == 2**ADDR_W cannot overflow.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 64'(a) < 64'(DEPTH);
    endfunction

    // Storage
    logic [DATA_W-1:0] mem [DEPTH];

    // Write buffer
    logic [ADDR_W-1:0]     wb_addr [WBUF_DEPTH];
    logic [DATA_W-1:0]     wb_data [WBUF_DEPTH];
    logic [WBUF_DEPTH-1:0] wb_valid;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;

    // Control
    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              io_ack;
    logic              io_ack_nxt;
    logic [DATA_W-1:0] io_rdata;
    logic              err_oor;

    logic              clearing;
    logic              cpu_wr_ok;
    logic              cpu_oor;
    logic              wb_full;
    logic              wb_empty;
    logic              drain;
    logic              drain_wr;
    logic              io_wr_req;
    logic              io_wr_oor;
    logic              push;
    logic              io_rd_done;
    logic              io_rd_oor;
    logic [DATA_W-1:0] io_rd_val;
    logic              clear_wr;
    logic [IDX_W-1:0]  clr_idx;

    // Combinational read ports
    assign IF_DATA   = in_range(IF_ADDR)   ? mem[IF_ADDR[IDX_W-1:0]]   : '0;
    assign CPU_RDATA = in_range(CPU_RADDR) ? mem[CPU_RADDR[IDX_W-1:0]] : '0;
    assign io_rd_val = in_range(IO_ADDR)   ? mem[IO_ADDR[IDX_W-1:0]]   : '0;

    // Request decode shared by buffer, FSM and memory write port
    assign clearing   = (state == ST_CLEAR);
    assign cpu_wr_ok  = CPU_WE && !clearing && in_range(CPU_WADDR);
    assign cpu_oor    = CPU_WE && !clearing && !in_range(CPU_WADDR);
    assign wb_full    = (count == CNT_W'(WBUF_DEPTH));
    assign wb_empty   = (count == '0);
    // Drain is gated on CPU_WE itself, so a dropped (OOR) CPU write still blocks it.
    assign drain      = !CPU_WE && !wb_empty;
    assign drain_wr   = drain && wb_valid[rd_ptr];
    assign io_wr_req  = (state == ST_IDLE) && IO_REQ && IO_WE;
    assign io_wr_oor  = io_wr_req && !in_range(IO_ADDR);
    // A full buffer can still accept when the head drains on the same edge.
    assign push       = io_wr_req && in_range(IO_ADDR) && (!wb_full || drain);
    assign io_rd_done = (state == ST_RD_WAIT) && wb_empty;
    assign io_rd_oor  = io_rd_done && !in_range(IO_ADDR);

`ifdef MEM_CLEAR_EN
    logic [IDX_W-1:0] clr_addr;
    logic             clr_done;

    assign clr_done = (clr_addr == IDX_W'(DEPTH - 1));
    assign clear_wr = clearing;
    assign clr_idx  = clr_addr;
    assign BUSY     = clearing;

    // Sweep address: restarts at 0 on every reset, advances while clearing
    always_ff @(posedge CLK) begin
        if (RST) begin
            clr_addr <= '0;
        end else if (clearing) begin
            clr_addr <= clr_addr + IDX_W'(1);
        end
    end
`else
    assign clear_wr = 1'b0;
    assign clr_idx  = '0;
    assign BUSY     = 1'b0;
`endif

    // IO handshake FSM next-state and acknowledge
    always_comb begin
        state_nxt  = state;
        io_ack_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (IO_REQ) begin
                    if (IO_WE) begin
                        if (push || io_wr_oor) begin
                            state_nxt  = ST_ACK;
                            io_ack_nxt = 1'b1;
                        end
                    end else begin
                        state_nxt = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (wb_empty) begin
                    state_nxt  = ST_ACK;
                    io_ack_nxt = 1'b1;
                end
            end
            ST_ACK: begin
                state_nxt = ST_IDLE;
            end
`ifdef MEM_CLEAR_EN
            ST_CLEAR: begin
                if (clr_done) begin
                    state_nxt = ST_IDLE;
                end
            end
`endif
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state, registered IO outputs and sticky range error
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_RESET;
            io_ack   <= 1'b0;
            io_rdata <= '0;
            err_oor  <= 1'b0;
        end else begin
            state  <= state_nxt;
            io_ack <= io_ack_nxt;
            if (io_rd_done) begin
                io_rdata <= io_rd_val;
            end
            if (cpu_oor || io_wr_oor || io_rd_oor) begin
                err_oor <= 1'b1;
            end
        end
    end

    // Write buffer: invalidate on CPU hit, pop on drain, push last so it wins
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            wb_valid <= '0;
        end else begin
            for (int i = 0; i < int'(WBUF_DEPTH); i++) begin
                if (cpu_wr_ok && wb_valid[i] && (wb_addr[i] == CPU_WADDR)) begin
                    wb_valid[i] <= 1'b0;
                end
            end
            if (drain) begin
                wb_valid[rd_ptr] <= 1'b0;
                rd_ptr           <= rd_ptr + PTR_W'(1);
            end
            if (push) begin
                wb_addr[wr_ptr]  <= IO_ADDR;
                wb_data[wr_ptr]  <= IO_WDATA;
                wb_valid[wr_ptr] <= 1'b1;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            case ({push, drain})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Single memory write port: clear sweep, CPU write, or buffer drain
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (clear_wr) begin
                mem[clr_idx] <= '0;
            end else if (cpu_wr_ok) begin
                mem[CPU_WADDR[IDX_W-1:0]] <= CPU_WDATA;
            end else if (drain_wr) begin
                mem[wb_addr[rd_ptr][IDX_W-1:0]] <= wb_data[rd_ptr];
            end
        end
    end

    assign IO_ACK     = io_ack;
    assign IO_RDATA   = io_rdata;
    assign WBUF_EMPTY = wb_empty;
    assign WBUF_FULL  = wb_full;
    assign ERR_OOR    = err_oor;

endmodule
